// File: rtl/dmem_sram_bridge.sv
// Bridges the 64-bit pipeline data-memory port onto a 16-bit asynchronous SRAM,
// splitting each access into little-endian halfword beats (SETUP then ACCESS per beat).
module dmem_sram_bridge #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       dmem_addr,
  input  logic [63:0]       dmem_dout,
  input  logic [1:0]        dmem_write_width,
  input  logic              dmem_rstrobe,
  input  logic              dmem_wstrobe,
  output logic [63:0]       dmem_din,
  output logic              dmem_cycle_complete,
  output logic              dmem_misaligned,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [1:0]        sram_be_n
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  function automatic logic f_misaligned(input logic [1:0] width, input logic [2:0] addr_lo);
    case (width)
      2'd0:    f_misaligned = (addr_lo != 3'd0);
      2'd1:    f_misaligned = (addr_lo[1:0] != 2'd0);
      2'd2:    f_misaligned = addr_lo[0];
      default: f_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] f_last_beat(input logic [1:0] width);
    case (width)
      2'd0:    f_last_beat = 2'd3;
      2'd1:    f_last_beat = 2'd1;
      default: f_last_beat = 2'd0;
    endcase
  endfunction

  // Byte accesses enable only the addressed lane; everything wider uses both lanes.
  function automatic logic [1:0] f_be_n(input logic [1:0] width, input logic lane_hi);
    if (width == 2'd3) begin
      f_be_n = lane_hi ? 2'b01 : 2'b10;
    end else begin
      f_be_n = 2'b00;
    end
  endfunction

  function automatic logic [15:0] f_wdata(input logic [1:0] width, input logic [63:0] data,
                                          input logic [1:0] beat);
    case (width)
      2'd3:    f_wdata = {data[7:0], data[7:0]};
      2'd2:    f_wdata = data[15:0];
      default: f_wdata = data[{beat, 4'd0} +: 16];
    endcase
  endfunction

  state_t              r_state;
  logic                r_write;
  logic [1:0]          r_width;
  logic [63:0]         r_dout;
  logic [ADDR_W-1:0]   r_base;
  logic                r_lane_hi;
  logic [1:0]          r_beat;
  logic [3:0]          r_wait;
  logic [63:0]         r_acc;

  logic                w_req;
  logic [1:0]          w_beat_nx;
  logic [63:0]         w_acc_next;
  logic                w_unused;

  assign w_req     = dmem_rstrobe | dmem_wstrobe;
  assign w_beat_nx = r_beat + 2'd1;
  // Address bits above the SRAM space alias and are deliberately dropped.
  assign w_unused  = &{1'b0, dmem_addr[63:ADDR_W+1]};

  // Read accumulator with the current beat's SRAM data merged in
  always_comb begin
    w_acc_next = r_acc;
    case (r_width)
      2'd3:    w_acc_next = {56'd0, (r_lane_hi ? sram_dq_in[15:8] : sram_dq_in[7:0])};
      2'd2:    w_acc_next = {48'd0, sram_dq_in};
      default: w_acc_next[{r_beat, 4'd0} +: 16] = sram_dq_in;
    endcase
  end

  // Transaction FSM with all pipeline and SRAM outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= ST_IDLE;
      r_write             <= 1'b0;
      r_width             <= 2'd0;
      r_dout              <= 64'd0;
      r_base              <= '0;
      r_lane_hi           <= 1'b0;
      r_beat              <= 2'd0;
      r_wait              <= 4'd0;
      r_acc               <= 64'd0;
      dmem_din            <= 64'd0;
      dmem_cycle_complete <= 1'b0;
      dmem_misaligned     <= 1'b0;
      sram_addr           <= '0;
      sram_dq_out         <= 16'd0;
      sram_dq_oe          <= 1'b0;
      sram_ce_n           <= 1'b1;
      sram_oe_n           <= 1'b1;
      sram_we_n           <= 1'b1;
      sram_be_n           <= 2'b11;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_write   <= dmem_wstrobe;
            r_width   <= dmem_write_width;
            r_dout    <= dmem_dout;
            r_base    <= dmem_addr[ADDR_W:1];
            r_lane_hi <= dmem_addr[0];
            r_beat    <= 2'd0;
            r_acc     <= 64'd0;
            if (f_misaligned(dmem_write_width, dmem_addr[2:0])) begin
              r_state             <= ST_DONE;
              dmem_cycle_complete <= 1'b1;
              dmem_misaligned     <= 1'b1;
              dmem_din            <= 64'd0;
            end else begin
              r_state     <= ST_SETUP;
              sram_ce_n   <= 1'b0;
              sram_addr   <= dmem_addr[ADDR_W:1];
              sram_be_n   <= f_be_n(dmem_write_width, dmem_addr[0]);
              sram_dq_out <= f_wdata(dmem_write_width, dmem_dout, 2'd0);
              sram_dq_oe  <= dmem_wstrobe;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_wait  <= WAIT_LAST;
          if (r_write) begin
            sram_we_n <= 1'b0;
          end else begin
            sram_oe_n <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!r_write) begin
              r_acc <= w_acc_next;
            end
            if (r_beat == f_last_beat(r_width)) begin
              r_state             <= ST_DONE;
              sram_ce_n           <= 1'b1;
              sram_be_n           <= 2'b11;
              sram_dq_oe          <= 1'b0;
              dmem_cycle_complete <= 1'b1;
              if (!r_write) begin
                dmem_din <= w_acc_next;
              end
            end else begin
              r_state     <= ST_SETUP;
              r_beat      <= w_beat_nx;
              sram_addr   <= r_base + {{(ADDR_W-2){1'b0}}, w_beat_nx};
              sram_dq_out <= f_wdata(r_width, r_dout, w_beat_nx);
            end
          end
        end
        ST_DONE: begin
          r_state             <= ST_IDLE;
          dmem_cycle_complete <= 1'b0;
          dmem_misaligned     <= 1'b0;
        end
        default: begin
          r_state             <= ST_IDLE;
          dmem_cycle_complete <= 1'b0;
          dmem_misaligned     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Two bridges (WAIT_CYCLES 1 and 3) see the same request stream, each with its own SRAM
// model; results are compared against a byte-addressed reference memory.
module tb_dmem_sram_bridge;

  localparam int          ADDR_W = 20;
  localparam logic [63:0] MASK   = (64'd1 << (ADDR_W + 1)) - 64'd1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [63:0]            dmem_addr;
  logic [63:0]            dmem_dout;
  logic [1:0]             dmem_write_width;
  logic [1:0]             rs;
  logic [1:0]             ws;
  logic [1:0][63:0]       din;
  logic [1:0]             cc;
  logic [1:0]             mis;
  logic [1:0][ADDR_W-1:0] saddr;
  logic [1:0][15:0]       dq_out;
  logic [1:0][15:0]       dq_in;
  logic [1:0]             dq_oe;
  logic [1:0]             ce_n;
  logic [1:0]             oe_n;
  logic [1:0]             we_n;
  logic [1:0][1:0]        be_n;

  logic [15:0]     smem [int];
  logic [7:0]      ref_mem [longint];
  logic [63:0]     last_din;
  logic [1:0][1:0] obs_be;
  int              errors = 0;
  int              checks = 0;

  always #5 clk = ~clk;

  dmem_sram_bridge #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_dout(dmem_dout),
    .dmem_write_width(dmem_write_width), .dmem_rstrobe(rs[0]), .dmem_wstrobe(ws[0]),
    .dmem_din(din[0]), .dmem_cycle_complete(cc[0]), .dmem_misaligned(mis[0]),
    .sram_addr(saddr[0]), .sram_dq_out(dq_out[0]), .sram_dq_in(dq_in[0]),
    .sram_dq_oe(dq_oe[0]), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
    .sram_we_n(we_n[0]), .sram_be_n(be_n[0])
  );

  dmem_sram_bridge #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_dout(dmem_dout),
    .dmem_write_width(dmem_write_width), .dmem_rstrobe(rs[1]), .dmem_wstrobe(ws[1]),
    .dmem_din(din[1]), .dmem_cycle_complete(cc[1]), .dmem_misaligned(mis[1]),
    .sram_addr(saddr[1]), .sram_dq_out(dq_out[1]), .sram_dq_in(dq_in[1]),
    .sram_dq_oe(dq_oe[1]), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
    .sram_we_n(we_n[1]), .sram_be_n(be_n[1])
  );

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] smem_rd(input int k, input int waddr);
    int key;
    key = (k << 24) | waddr;
    return smem.exists(key) ? smem[key] : 16'h0000;
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a, input int nb);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < nb; i++) begin
      longint key;
      key = longint'((a + 64'(i)) & MASK);
      if (ref_mem.exists(key)) v[8*i +: 8] = ref_mem[key];
    end
    return v;
  endfunction

  task automatic ref_write(input logic [63:0] a, input int nb, input logic [63:0] d);
    for (int i = 0; i < nb; i++) begin
      longint key;
      key = longint'((a + 64'(i)) & MASK);
      ref_mem[key] = d[8*i +: 8];
    end
  endtask

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM models: write enabled lanes while selected with we_n low, drive data while oe_n low
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [15:0] word;
      word = smem_rd(k, int'(saddr[k]));
      if (!ce_n[k] && !we_n[k]) begin
        if (!be_n[k][0]) word[7:0] = dq_out[k][7:0];
        if (!be_n[k][1]) word[15:8] = dq_out[k][15:8];
        smem[(k << 24) | int'(saddr[k])] = word;
      end
      dq_in[k] = (!ce_n[k] && !oe_n[k]) ? word : 16'($urandom);
    end
  end

  task automatic run_txn(input logic wr, input logic rd, input logic [1:0] w,
                         input logic [63:0] a, input logic [63:0] d, input logic scramble,
                         input string tag);
    int          nb, beats, cyc, wt;
    int          we_run[2], we_cnt[2], oe_cnt[2], ce_cnt[2], drv_cnt[2];
    logic [1:0]  done;
    logic        misal;
    logic        is_rd;
    logic [63:0] exp_din;
    nb      = 8 >> w;
    beats   = (nb + 1) / 2;
    misal   = ((a[2:0] & 3'(nb - 1)) != 3'd0);
    is_rd   = !wr;
    exp_din = misal ? 64'd0 : ref_read(a, nb);
    for (int k = 0; k < 2; k++) begin
      we_run[k] = 0; we_cnt[k] = 0; oe_cnt[k] = 0; ce_cnt[k] = 0; drv_cnt[k] = 0;
    end
    done = 2'b00;
    cyc  = 0;
    dmem_addr = a; dmem_dout = d; dmem_write_width = w;
    rs = {rd, rd}; ws = {wr, wr};
    while (done != 2'b11 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (scramble) begin
        dmem_addr        = {$urandom, $urandom};
        dmem_dout        = {$urandom, $urandom};
        dmem_write_width = 2'($urandom);
      end
      for (int k = 0; k < 2; k++) begin
        if (!done[k]) begin
          wt = wait_of(k);
          if (!ce_n[k]) ce_cnt[k]++;
          if (!oe_n[k]) oe_cnt[k]++;
          if (dq_oe[k]) drv_cnt[k]++;
          if (!we_n[k]) begin
            we_cnt[k]++;
            we_run[k]++;
            obs_be[k] = be_n[k];
          end else if (we_run[k] != 0) begin
            check_value({tag, " we_n pulse"}, 64'(we_run[k]), 64'(wt));
            we_run[k] = 0;
          end
          if (cc[k]) begin
            done[k] = 1'b1;
            rs[k] = 1'b0;
            ws[k] = 1'b0;
            check_value({tag, " latency"}, 64'(cyc), misal ? 64'd1 : 64'(beats * (1 + wt) + 1));
            check_value({tag, " misaligned"}, 64'(mis[k]), 64'(misal));
            if (is_rd || misal) check_value({tag, " rdata"}, din[k], exp_din);
            check_value({tag, " ce_n cycles"}, 64'(ce_cnt[k]), misal ? 64'd0 : 64'(beats * (1 + wt)));
            check_value({tag, " we_n cycles"}, 64'(we_cnt[k]), (wr && !misal) ? 64'(beats * wt) : 64'd0);
            check_value({tag, " oe_n cycles"}, 64'(oe_cnt[k]), (is_rd && !misal) ? 64'(beats * wt) : 64'd0);
            check_value({tag, " dq_oe cycles"}, 64'(drv_cnt[k]), (wr && !misal) ? 64'(beats * (1 + wt)) : 64'd0);
          end
        end
      end
    end
    if (done != 2'b11) begin
      check_value({tag, " completion timeout"}, 64'(done), 64'd3);
      rs = 2'b00;
      ws = 2'b00;
    end
    if (is_rd || misal) last_din = exp_din;
    if (wr && !misal) ref_write(a, nb, d);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_value({tag, " idle flags"}, 64'({cc[k], mis[k]}), 64'd0);
      check_value({tag, " din held"}, din[k], last_din);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_value({tag, " din"}, din[k], 64'd0);
      check_value({tag, " controls"}, 64'({cc[k], mis[k], ce_n[k], oe_n[k], we_n[k], be_n[k], dq_oe[k]}),
                  64'b0011_1110);
      check_value({tag, " addr/dq"}, 64'({saddr[k], dq_out[k]}), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] dr;
    int          pulses;
    rst = 1'b1; dmem_addr = 64'd0; dmem_dout = 64'd0; dmem_write_width = 2'd0;
    rs = 2'b00; ws = 2'b00; last_din = 64'd0; obs_be = '1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 1'b0, 2'd0, 64'h10, 64'h0123_4567_89AB_CDEF, 1'b0, "w64");
    for (int k = 0; k < 2; k++) begin
      check_value("w64 word8", 64'(smem_rd(k, 8)), 64'hCDEF);
      check_value("w64 word9", 64'(smem_rd(k, 9)), 64'h89AB);
      check_value("w64 word10", 64'(smem_rd(k, 10)), 64'h4567);
      check_value("w64 word11", 64'(smem_rd(k, 11)), 64'h0123);
    end
    run_txn(1'b0, 1'b1, 2'd0, 64'h10, 64'd0, 1'b0, "r64");

    run_txn(1'b1, 1'b0, 2'd2, 64'h2, 64'h1234, 1'b0, "w16");
    run_txn(1'b1, 1'b0, 2'd3, 64'h3, 64'h5A, 1'b0, "w8");
    for (int k = 0; k < 2; k++) begin
      check_value("w8 be_n", 64'(obs_be[k]), 64'b01);
      check_value("w8 word1", 64'(smem_rd(k, 1)), 64'h5A34);
    end
    run_txn(1'b0, 1'b1, 2'd3, 64'h3, 64'd0, 1'b0, "r8 hi");
    run_txn(1'b0, 1'b1, 2'd3, 64'h2, 64'd0, 1'b0, "r8 lo");
    run_txn(1'b0, 1'b1, 2'd1, 64'h6, 64'd0, 1'b0, "r32 misaligned");
    run_txn(1'b1, 1'b1, 2'd1, 64'h20, 64'h1122_3344_CAFE_F00D, 1'b0, "both strobes");
    run_txn(1'b0, 1'b1, 2'd1, 64'h20, 64'd0, 1'b0, "both readback");
    run_txn(1'b1, 1'b0, 2'd0, 64'h30, 64'hFEED_0BAD_D00D_BEEF, 1'b1, "scrambled w");
    run_txn(1'b0, 1'b1, 2'd0, 64'h30, 64'd0, 1'b1, "scrambled r");
    run_txn(1'b1, 1'b0, 2'd0, (MASK - 64'd7) | (64'hABC << 40), 64'hA1A2_B3B4_C5C6_D7D8, 1'b0, "alias w");
    for (int k = 0; k < 2; k++) check_value("alias top word", 64'(smem_rd(k, 20'hFFFFF)), 64'hA1A2);
    run_txn(1'b0, 1'b1, 2'd0, MASK - 64'd7, 64'd0, 1'b0, "alias r");

    // Abort a 64-bit write during its third beat, then redo it cleanly
    dmem_addr = 64'h40; dmem_dout = {$urandom, $urandom}; dmem_write_width = 2'd0;
    ws = 2'b11; rs = 2'b00;
    repeat (5) @(negedge clk);
    rst = 1'b1; ws = 2'b00;
    @(negedge clk);
    check_reset_state("mid reset");
    rst = 1'b0; last_din = 64'd0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(cc[0]) + int'(cc[1]);
    end
    check_value("no pulse after abort", 64'(pulses), 64'd0);
    dr = {$urandom, $urandom};
    run_txn(1'b1, 1'b0, 2'd0, 64'h40, dr, 1'b0, "post-reset w");
    run_txn(1'b0, 1'b1, 2'd0, 64'h40, 64'd0, 1'b0, "post-reset r");

    for (int n = 0; n < 60; n++) begin
      logic [1:0]  w;
      logic [63:0] a;
      int          nb, op;
      w  = 2'($urandom_range(0, 3));
      nb = 8 >> w;
      a  = 64'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
      case ($urandom_range(0, 7))
        0:       a = (MASK - 64'd63) + a;
        1:       a = a | ({$urandom, $urandom} << (ADDR_W + 1));
        default: a = a;
      endcase
      op = $urandom_range(0, 3);
      run_txn((op == 0) || (op == 3), (op != 0), w, a, {$urandom, $urandom},
              1'($urandom_range(0, 1)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_sram_bridge.md
DMEM_SRAM_BRIDGE -- requirements
Module: dmem_sram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, meaning SRAM word-address width (16-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 1-15, meaning SRAM access-strobe cycles per beat.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- dmem_addr  in  64  byte address from pipeline.
- dmem_dout  in  64  write data from pipeline.
- dmem_write_width  in  2  access width: 0=64b, 1=32b, 2=16b, 3=8b (applies to reads and writes).
- dmem_rstrobe  in  1  read request.
- dmem_wstrobe  in  1  write request.
- dmem_din  out  64  read data to pipeline.
- dmem_cycle_complete  out  1  one-cycle completion pulse.
- dmem_misaligned  out  1  error flag, valid with completion.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_in  in  16  SRAM read data.
- sram_dq_oe  out  1  data-bus drive enable.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low SRAM controls.
- sram_be_n  out  2  active-low byte lanes; bit 1 = dq[15:8].

Function
REQ-004 SHALL be a responder: initiator holds a strobe high until it sees dmem_cycle_complete; the bridge accepts a request only in IDLE.
REQ-005 SHALL latch addr, dout, width and direction at acceptance; later input changes are ignored until the next IDLE.
REQ-006 SHALL give wstrobe priority when both strobes are high in the same acceptance cycle.
REQ-007 SHALL implement FSM IDLE -> SETUP -> ACCESS -> (SETUP for next beat | DONE) -> IDLE.
REQ-008 SHALL perform 4 beats for width 0, 2 for width 1, and 1 for widths 2 and 3.
REQ-009 SHALL drive sram_addr = dmem_addr[ADDR_W:1] + beat index, with beat 0 as the least-significant halfword (little-endian).
REQ-010 SHALL ignore address bits above ADDR_W (aliasing) and let sram_addr wrap modulo 2^ADDR_W.
REQ-011 SHALL hold sram_ce_n low, and sram_addr, be_n and dq_out stable, for all of SETUP and ACCESS of a beat.
REQ-012 SHALL assert sram_we_n low (write) or sram_oe_n low (read) only in ACCESS, which lasts WAIT_CYCLES cycles.
REQ-013 SHALL assert sram_dq_oe during SETUP and ACCESS of write beats only.
REQ-014 SHALL sample sram_dq_in on the last ACCESS cycle of each read beat.
REQ-015 SHALL, for width 3, enable only lane dmem_addr[0] and drive the write byte on both lanes.
REQ-016 SHALL, for width 3 reads, return the selected lane in dmem_din[7:0].
REQ-017 SHALL zero-extend narrow reads into dmem_din[width-1:0] and hold dmem_din until the next completion.
REQ-018 SHALL flag a misaligned request (16b with addr[0]!=0, 32b with addr[1:0]!=0, 64b with addr[2:0]!=0) by going IDLE->DONE with no SRAM activity, dmem_misaligned=1, and dmem_din=0.
REQ-019 SHALL assert dmem_cycle_complete for exactly the DONE cycle; dmem_misaligned is valid only in that cycle and 0 otherwise.
REQ-020 SHALL complete an aligned request with latency beats*(1+WAIT_CYCLES)+1 cycles after the acceptance edge (width 3, WAIT_CYCLES=1: 3; width 0: 9).
REQ-021 SHALL never issue back-to-back requests without at least one IDLE cycle between DONE and the next SETUP.

Reset
REQ-022 SHALL, on rst high at a clock edge, enter IDLE and set:
- dmem_din=0, dmem_cycle_complete=0, dmem_misaligned=0.
- sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=2'b11, sram_dq_oe=0.
- sram_addr=0, sram_dq_out=0.
REQ-023 SHALL, when reset occurs mid-transaction, abort with no completion pulse, and the aborted request is not resumed after reset.

Verification
REQ-024 64b write then read, addr 0x10, data 0x0123456789ABCDEF, WAIT_CYCLES=1 -> SRAM words 8..11 = EF CD / AB 89 / 67 45 / 23 01 (low halfword first); read returns the same value; complete pulses 9 cycles after each acceptance.
REQ-025 8b write 0x5A to addr 0x3 -> single beat at word 1, be_n=2'b01, other byte unchanged; 8b read of 0x3 -> dmem_din=0x5A.
REQ-026 32b read at addr 0x6 -> no ce_n activity; complete and misaligned high together 1 cycle after acceptance; dmem_din=0.
REQ-027 rstrobe and wstrobe both high -> write performed (we_n pulses, oe_n stays high).
REQ-028 rst asserted during beat 2 of a 64b write -> next edge: ce_n=1, we_n=1, dq_oe=0, no complete pulse; a new request after reset completes normally.
REQ-029 WAIT_CYCLES=3 with dmem_addr changed mid-transaction -> we_n low for exactly 3 cycles per beat; the latched address is used throughout.
